tx_word_serializer: RTL

Upstream feeder for the UART transmitter. Buffers full-width words from the debug/pipeline side in a small FIFO and splits each word into DATA_BITS-wide bytes, LSB byte first. Drives the transmitter's start/data inputs and paces bytes on its done tick. Sits between the debug unit and the UART TX stage.

---
 rtl/tx_word_serializer_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 71 +++++++
 rtl/tx_word_serializer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/tx_word_serializer_pkg.sv
// -----------------------------------------------------------------------------
// tx_word_serializer_pkg
// Shared definitions for the UART TX word serializer.
//   - Default byte/word/FIFO geometry used as parameter defaults.
//   - Serializer FSM state encoding (IDLE/START/WAIT, 2-bit).
//   - cnt_width(): counter width able to hold 0..n-1 (minimum 1 bit).
// -----------------------------------------------------------------------------
package tx_word_serializer_pkg;

    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DEFAULT_WORD_BITS  = 32;
    localparam int DEFAULT_FIFO_DEPTH = 4;
    localparam int DEFAULT_PTR_BITS   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Width of a counter that must reach n-1; never collapses to zero bits.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO holding full-width words for the serializer.
// Ports:
//   i_clock    in   rising-edge clock
//   i_reset    in   asynchronous active-low reset (clears pointers and count)
//   push       in   write request; ignored while full
//   push_data  in   WIDTH-bit word written on an accepted push
//   pop        in   read request; ignored while empty
//   pop_data   out  head word (valid whenever !empty)
//   full       out  count == DEPTH, decoded from the count register only
//   empty      out  count == 0, decoded from the count register only
// A push is refused while full even if a pop happens in the same cycle, so
// full never depends combinationally on pop.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = 2
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS + 1)'(DEPTH);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [PTR_BITS:0]   count;
    logic                do_push;
    logic                do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; an entry is only read
    // after it has been written, so clearing it would add logic for nothing.
    always_ff @(posedge i_clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tx_word_serializer.sv
// -----------------------------------------------------------------------------
// tx_word_serializer
// Buffers words from the debug/pipeline side and feeds them to the UART TX
// one DATA_BITS byte at a time, least-significant byte first.
// Ports:
//   i_clock         in   rising-edge clock
//   i_reset         in   asynchronous active-low reset
//   i_word_valid    in   upstream word present this cycle
//   i_word          in   WORD_BITS word to transmit
//   o_word_ready    out  FIFO can accept a word (not full)
//   o_drop          out  registered pulse: a word arrived while full
//   i_tx_done_tick  in   UART TX finished the current byte
//   o_tx_start      out  one-cycle start pulse to the UART TX
//   o_tx_data       out  byte to transmit, held from start to done tick
//   o_busy          out  FIFO non-empty or a word is in flight
// -----------------------------------------------------------------------------
module tx_word_serializer
    import tx_word_serializer_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int WORD_BITS  = DEFAULT_WORD_BITS,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int PTR_BITS   = DEFAULT_PTR_BITS
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_word_valid,
    input  logic [WORD_BITS-1:0] i_word,
    output logic                 o_word_ready,
    output logic                 o_drop,
    input  logic                 i_tx_done_tick,
    output logic                 o_tx_start,
    output logic [DATA_BITS-1:0] o_tx_data,
    output logic                 o_busy
);

    localparam int                  BYTES     = WORD_BITS / DATA_BITS;
    localparam int                  CNT_BITS  = cnt_width(BYTES);
    localparam logic [CNT_BITS-1:0] LAST_BYTE = CNT_BITS'(BYTES - 1);

    state_t               state;
    state_t               state_next;
    logic [WORD_BITS-1:0] word_reg;
    logic [WORD_BITS-1:0] word_next;
    logic [CNT_BITS-1:0]  byte_cnt;
    logic [CNT_BITS-1:0]  cnt_next;
    logic                 drop_reg;

    logic                 fifo_pop;
    logic [WORD_BITS-1:0] fifo_data;
    logic                 fifo_full;
    logic                 fifo_empty;

    sync_fifo #(
        .WIDTH    (WORD_BITS),
        .DEPTH    (FIFO_DEPTH),
        .PTR_BITS (PTR_BITS)
    ) u_fifo (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .push      (i_word_valid),
        .push_data (i_word),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        word_next  = word_reg;
        cnt_next   = byte_cnt;
        fifo_pop   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    word_next  = fifo_data;
                    cnt_next   = '0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                // Done ticks are ignored here; the byte has only just started.
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done_tick) begin
                    if (byte_cnt == LAST_BYTE) begin
                        state_next = ST_IDLE;
                    end else begin
                        // Shifting brings the next byte into the low lane.
                        word_next  = word_reg >> DATA_BITS;
                        cnt_next   = byte_cnt + 1'b1;
                        state_next = ST_START;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state    <= ST_IDLE;
            word_reg <= '0;
            byte_cnt <= '0;
            drop_reg <= 1'b0;
        end else begin
            state    <= state_next;
            word_reg <= word_next;
            byte_cnt <= cnt_next;
            drop_reg <= i_word_valid && fifo_full;
        end
    end

    // All outputs decode registers only; nothing reaches them from inputs.
    assign o_word_ready = !fifo_full;
    assign o_drop       = drop_reg;
    assign o_tx_start   = (state == ST_START);
    assign o_tx_data    = word_reg[DATA_BITS-1:0];
    assign o_busy       = (state != ST_IDLE) || !fifo_empty;

endmodule
